// File: rtl/vpifo_req_sched_pkg.sv
// Shared parameters, op encoding and response-pipe payload for the vPIFO request scheduler.
// The optional VPIFO_SCHED_STATS_EN build uses no extra package content.
package vpifo_req_sched_pkg;

  function automatic int unsigned tree_cap(input int unsigned levels);
    return (32'd1 << (levels + 32'd1)) - 32'd2;
  endfunction

  function automatic int unsigned bits_for(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

  localparam int unsigned PTW           = 16;
  localparam int unsigned LEVEL         = 4;
  localparam int unsigned TREE_NUM      = 4;
  localparam int unsigned NREQ          = 4;
  localparam int unsigned POP_GAP       = 2;
  localparam int unsigned POP_LAT       = 2;
  localparam int unsigned CAP           = tree_cap(LEVEL);
  localparam int unsigned TREE_NUM_BITS = bits_for(TREE_NUM);
  localparam int unsigned RID_BITS      = bits_for(NREQ);
  localparam int unsigned OCC_W         = $clog2(CAP + 1);
  localparam int unsigned GAP_W         = bits_for(POP_GAP);

  typedef enum logic {
    OP_PUSH = 1'b0,
    OP_POP  = 1'b1
  } op_e;

  typedef struct packed {
    logic [RID_BITS-1:0]      req_id;
    logic [TREE_NUM_BITS-1:0] tree_id;
  } rsp_t;

endpackage

// File: rtl/vpifo_req_sched_if.sv
// Requester, PIFO-lane and response signals of the vPIFO request scheduler.
// Slave modport is the scheduler; master is the requester/lane environment.
interface vpifo_req_sched_if;
  import vpifo_req_sched_pkg::*;

  logic [NREQ-1:0]                     req_valid;
  logic [NREQ-1:0]                     req_op;
  logic [NREQ-1:0][TREE_NUM_BITS-1:0]  req_tree_id;
  logic [NREQ-1:0][PTW-1:0]            req_data;
  logic [NREQ-1:0]                     req_ready;
  logic                                push;
  logic                                pop;
  logic [TREE_NUM_BITS-1:0]            tree_id;
  logic [PTW-1:0]                      push_data;
  logic                                task_fifo_full;
  logic [PTW-1:0]                      pop_data;
  logic                                rsp_valid;
  logic [RID_BITS-1:0]                 rsp_req_id;
  logic [TREE_NUM_BITS-1:0]            rsp_tree_id;
  logic [PTW-1:0]                      rsp_data;

  modport slave (
    input  req_valid, req_op, req_tree_id, req_data, task_fifo_full, pop_data,
    output req_ready, push, pop, tree_id, push_data,
           rsp_valid, rsp_req_id, rsp_tree_id, rsp_data
  );

  modport master (
    output req_valid, req_op, req_tree_id, req_data, task_fifo_full, pop_data,
    input  req_ready, push, pop, tree_id, push_data,
           rsp_valid, rsp_req_id, rsp_tree_id, rsp_data
  );
endinterface

// File: rtl/vpifo_req_sched_rr_arbiter.sv
// Rotate-priority one-hot arbiter; search starts at ptr, ptr moves past the winner on a grant.
module vpifo_req_sched_rr_arbiter
  import vpifo_req_sched_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     eligible,
  output logic [NREQ-1:0]     grant_c,
  output logic [RID_BITS-1:0] winner_c,
  output logic                any_c
);

  logic [RID_BITS-1:0] ptr;
  logic [RID_BITS-1:0] idx;

  always_comb begin
    grant_c  = '0;
    winner_c = '0;
    any_c    = 1'b0;
    idx      = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = RID_BITS'((32'(ptr) + i) % NREQ);
      if (!any_c && eligible[idx]) begin
        any_c         = 1'b1;
        winner_c      = idx;
        grant_c[idx]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (any_c) begin
      ptr <= (32'(winner_c) == NREQ - 1) ? '0 : winner_c + RID_BITS'(1);
    end
  end

endmodule

// File: rtl/vpifo_req_sched.sv
// Request scheduler for one PIFO lane: RR arbitration, per-tree occupancy, pop spacing, tagged responses.
// Optional VPIFO_SCHED_STATS_EN adds per-requester saturating grant counters (grant_cnt).
module vpifo_req_sched
  import vpifo_req_sched_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  vpifo_req_sched_if.slave       bus
`ifdef VPIFO_SCHED_STATS_EN
  ,
  output logic [NREQ-1:0][31:0]  grant_cnt
`endif
);

  logic [OCC_W-1:0]         occ [TREE_NUM];
  logic [GAP_W-1:0]         gap [TREE_NUM];
  logic [NREQ-1:0]          eligible;
  logic [NREQ-1:0]          grant_c;
  logic [RID_BITS-1:0]      winner_c;
  logic                     any_c;
  op_e                      win_op_c;
  logic [TREE_NUM_BITS-1:0] win_tree_c;
  logic [PTW-1:0]           win_data_c;
  logic [RID_BITS-1:0]      issue_rid;
  logic [POP_LAT-1:0]       pipe_vld;
  rsp_t                     pipe_info [POP_LAT];

  // Nothing is granted while held in reset or while the lane backpressures.
  always_comb begin
    eligible = '0;
    for (int unsigned r = 0; r < NREQ; r++) begin
      eligible[r] = bus.req_valid[r] & ~bus.task_fifo_full & rst_n &
                    ((op_e'(bus.req_op[r]) == OP_PUSH)
                      ? (32'(occ[bus.req_tree_id[r]]) < CAP)
                      : ((occ[bus.req_tree_id[r]] != '0) && (gap[bus.req_tree_id[r]] == '0)));
    end
  end

  vpifo_req_sched_rr_arbiter u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .eligible (eligible),
    .grant_c  (grant_c),
    .winner_c (winner_c),
    .any_c    (any_c)
  );

  assign bus.req_ready = grant_c;
  assign win_op_c      = op_e'(bus.req_op[winner_c]);
  assign win_tree_c    = bus.req_tree_id[winner_c];
  assign win_data_c    = bus.req_data[winner_c];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.push      <= 1'b0;
      bus.pop       <= 1'b0;
      bus.tree_id   <= '0;
      bus.push_data <= '0;
      issue_rid     <= '0;
    end else begin
      bus.push      <= any_c && (win_op_c == OP_PUSH);
      bus.pop       <= any_c && (win_op_c == OP_POP);
      bus.tree_id   <= any_c ? win_tree_c : '0;
      bus.push_data <= (any_c && (win_op_c == OP_PUSH)) ? win_data_c : '0;
      issue_rid     <= any_c ? winner_c : '0;
    end
  end

  // Occupancy follows handshakes; a pop arms the tree's spacing timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned t = 0; t < TREE_NUM; t++) begin
        occ[t] <= '0;
        gap[t] <= '0;
      end
    end else begin
      for (int unsigned t = 0; t < TREE_NUM; t++) begin
        if (any_c && (32'(win_tree_c) == t)) begin
          occ[t] <= (win_op_c == OP_PUSH) ? occ[t] + OCC_W'(1) : occ[t] - OCC_W'(1);
        end
        if (any_c && (32'(win_tree_c) == t) && (win_op_c == OP_POP)) begin
          gap[t] <= GAP_W'(POP_GAP - 1);
        end else if (gap[t] != '0) begin
          gap[t] <= gap[t] - GAP_W'(1);
        end
      end
    end
  end

  // Tag pipe aligned to the issued pop; reset flushes anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld <= '0;
      for (int unsigned i = 0; i < POP_LAT; i++) begin
        pipe_info[i] <= '0;
      end
    end else begin
      pipe_vld[0]  <= bus.pop;
      pipe_info[0] <= bus.pop ? rsp_t'{req_id: issue_rid, tree_id: bus.tree_id} : '0;
      for (int unsigned i = 1; i < POP_LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_info[i] <= pipe_info[i-1];
      end
    end
  end

  assign bus.rsp_valid   = pipe_vld[POP_LAT-1];
  assign bus.rsp_req_id  = pipe_info[POP_LAT-1].req_id;
  assign bus.rsp_tree_id = pipe_info[POP_LAT-1].tree_id;
  // Lane data arrives in the response cycle itself, so it is passed straight through.
  assign bus.rsp_data    = pipe_vld[POP_LAT-1] ? bus.pop_data : '0;

`ifdef VPIFO_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt <= '0;
    end else begin
      for (int unsigned r = 0; r < NREQ; r++) begin
        if (grant_c[r] && (grant_cnt[r] != '1)) begin
          grant_cnt[r] <= grant_cnt[r] + 32'd1;
        end
      end
    end
  end
`else
  // Statistics build option disabled: no grant counters.
`endif

endmodule

// File: tb/tb_vpifo_req_sched.sv
// Directed bench for vpifo_req_sched with a small min-first PIFO lane model driving pop_data.
// Connects grant_cnt when VPIFO_SCHED_STATS_EN is defined.
module tb_vpifo_req_sched;
  import vpifo_req_sched_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vpifo_req_sched_if bus ();

`ifdef VPIFO_SCHED_STATS_EN
  logic [NREQ-1:0][31:0] grant_cnt;
`endif

  vpifo_req_sched dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef VPIFO_SCHED_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  // Lane model: per-tree queues, pop returns the minimum POP_LAT cycles after the pop.
  typedef logic [PTW-1:0] q_t [$];
  q_t             pifo_q [TREE_NUM];
  logic [PTW-1:0] lane1 = '0;
  logic [PTW-1:0] lane2 = '0;
  assign bus.pop_data = lane2;

  always @(posedge clk or negedge rst_n) begin : lane_model
    int unsigned tq;
    int          mi;
    if (!rst_n) begin
      lane1 = '0;
      lane2 = '0;
      for (int t = 0; t < int'(TREE_NUM); t++) pifo_q[t].delete();
    end else begin
      lane2 = lane1;
      lane1 = '0;
      tq    = 32'(bus.tree_id);
      if (bus.push) pifo_q[tq].push_back(bus.push_data);
      if (bus.pop && (pifo_q[tq].size() > 0)) begin
        mi = 0;
        for (int k = 1; k < pifo_q[tq].size(); k++)
          if (pifo_q[tq][k] < pifo_q[tq][mi]) mi = k;
        lane1 = pifo_q[tq][mi];
        pifo_q[tq].delete(mi);
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic v, input logic op, input int t, input int d);
    bus.req_valid[r]   = v;
    bus.req_op[r]      = op;
    bus.req_tree_id[r] = TREE_NUM_BITS'(t);
    bus.req_data[r]    = PTW'(d);
  endtask

  task automatic clr_reqs();
    bus.req_valid   = '0;
    bus.req_op      = '0;
    bus.req_tree_id = '0;
    bus.req_data    = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0]  rdy_x [5];
    logic        pop_x [5];
    logic        rv_x  [5];
    logic [15:0] rd_x  [5];
    rdy_x = '{4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0000};
    pop_x = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    rv_x  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    rd_x  = '{16'd0, 16'd0, 16'd5, 16'd0, 16'd9};

    clr_reqs();
    bus.task_fifo_full = 1'b0;

    // 1: reset with random inputs, then first grant goes to lowest eligible index
    repeat (4) begin
      bus.req_valid      = 4'($urandom);
      bus.req_op         = 4'($urandom);
      bus.req_tree_id    = 8'($urandom);
      bus.req_data       = {$urandom, $urandom};
      bus.task_fifo_full = 1'($urandom);
      #3;
      chk("rst_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_issue", 32'({bus.push, bus.pop, bus.tree_id, bus.push_data}), 32'd0);
      chk("rst_rsp", 32'({bus.rsp_valid, bus.rsp_req_id, bus.rsp_tree_id}), 32'd0);
      chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
      tick();
    end
    clr_reqs();
    bus.task_fifo_full = 1'b0;
    set_req(1, 1'b1, OP_PUSH, 3, 77);
    set_req(3, 1'b1, OP_PUSH, 3, 88);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_grant", 32'(bus.req_ready), 32'b0010);
    tick();
    chk("first_push", 32'({bus.push, bus.pop, bus.tree_id, bus.push_data}), 32'({1'b1, 1'b0, 2'd3, 16'd77}));
    clr_reqs();

    // 2: fill tree1 to capacity, the extra push waits until a pop frees a slot
    for (int i = 0; i < 30; i++) begin
      set_req(0, 1'b1, OP_PUSH, 1, 4096 + i);
      @(negedge clk);
      chk("fill_ready", 32'(bus.req_ready), 32'b0001);
      tick();
      chk("fill_push", 32'({bus.push, bus.pop, bus.tree_id, bus.push_data}),
          32'({1'b1, 1'b0, 2'd1, 16'(4096 + i)}));
    end
    set_req(0, 1'b1, OP_PUSH, 1, 5000);
    repeat (2) begin
      @(negedge clk);
      chk("full_hold", 32'(bus.req_ready), 32'd0);
      tick();
      chk("full_noissue", 32'({bus.push, bus.pop}), 32'd0);
    end
    set_req(1, 1'b1, OP_POP, 1, 0);
    @(negedge clk);
    chk("drain_ready", 32'(bus.req_ready), 32'b0010);
    tick();
    chk("drain_pop", 32'({bus.push, bus.pop, bus.tree_id}), 32'({1'b0, 1'b1, 2'd1}));
    set_req(1, 1'b0, OP_POP, 1, 0);
    @(negedge clk);
    chk("refill_ready", 32'(bus.req_ready), 32'b0001);
    tick();
    chk("refill_push", 32'({bus.push, bus.pop, bus.tree_id, bus.push_data}), 32'({1'b1, 1'b0, 2'd1, 16'd5000}));
    clr_reqs();
    tick();
    chk("drain_rsp", 32'({bus.rsp_valid, bus.rsp_req_id, bus.rsp_tree_id, bus.rsp_data}),
        32'({1'b1, 2'd1, 2'd1, 16'd4096}));

    // 3: pop to an empty tree never blocks a streaming pusher
    set_req(2, 1'b1, OP_POP, 2, 0);
    for (int i = 0; i < 6; i++) begin
      set_req(3, 1'b1, OP_PUSH, 3, 100 + i);
      @(negedge clk);
      chk("starve_ready", 32'(bus.req_ready), 32'b1000);
      tick();
      chk("starve_push", 32'({bus.push, bus.pop, bus.tree_id, bus.push_data}),
          32'({1'b1, 1'b0, 2'd3, 16'(100 + i)}));
    end
    clr_reqs();

    // 4: two contending pushers alternate
    for (int i = 0; i < 6; i++) begin
      set_req(0, 1'b1, OP_PUSH, 3, 200 + i);
      set_req(1, 1'b1, OP_PUSH, 2, 300 + i);
      @(negedge clk);
      chk("alt_ready", 32'(bus.req_ready), (i % 2 == 0) ? 32'b0001 : 32'b0010);
      tick();
      chk("alt_push", 32'({bus.push, bus.pop, bus.tree_id, bus.push_data}),
          (i % 2 == 0) ? 32'({1'b1, 1'b0, 2'd3, 16'(200 + i)}) : 32'({1'b1, 1'b0, 2'd2, 16'(300 + i)}));
    end
    clr_reqs();

    // 5: back-to-back pops on one tree are spaced by POP_GAP, responses in order
    set_req(0, 1'b1, OP_PUSH, 0, 9);
    @(negedge clk);
    chk("gap_fill0", 32'(bus.req_ready), 32'b0001);
    tick();
    set_req(0, 1'b1, OP_PUSH, 0, 5);
    @(negedge clk);
    chk("gap_fill1", 32'(bus.req_ready), 32'b0001);
    tick();
    clr_reqs();
    for (int j = 0; j < 5; j++) begin
      set_req(1, (j < 3), OP_POP, 0, 0);
      @(negedge clk);
      chk("gap_ready", 32'(bus.req_ready), 32'(rdy_x[j]));
      tick();
      chk("gap_pop", 32'({bus.pop, bus.tree_id}), 32'({pop_x[j], 2'd0}));
      chk("gap_rsp", 32'({bus.rsp_valid, bus.rsp_req_id, bus.rsp_tree_id, bus.rsp_data}),
          rv_x[j] ? 32'({1'b1, 2'd1, 2'd0, rd_x[j]}) : 32'd0);
    end
    clr_reqs();

    // 6: lane backpressure stops grants but an in-flight pop still responds
    set_req(1, 1'b1, OP_POP, 1, 0);
    @(negedge clk);
    chk("bp_pre_ready", 32'(bus.req_ready), 32'b0010);
    tick();
    chk("bp_pre_pop", 32'(bus.pop), 32'd1);
    bus.task_fifo_full = 1'b1;
    set_req(0, 1'b1, OP_PUSH, 3, 1);
    set_req(2, 1'b1, OP_PUSH, 2, 2);
    set_req(3, 1'b1, OP_PUSH, 3, 3);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_ready", 32'(bus.req_ready), 32'd0);
      tick();
      chk("bp_issue", 32'({bus.push, bus.pop}), 32'd0);
      chk("bp_rsp", 32'({bus.rsp_valid, bus.rsp_req_id, bus.rsp_tree_id, bus.rsp_data}),
          (k == 1) ? 32'({1'b1, 2'd1, 2'd1, 16'd4097}) : 32'd0);
    end
    bus.task_fifo_full = 1'b0;
    clr_reqs();

    // 7: reset with a pop in flight drops its response and clears state
    set_req(1, 1'b1, OP_POP, 1, 0);
    @(negedge clk);
    chk("mid_rst_ready", 32'(bus.req_ready), 32'b0010);
    tick();
    chk("mid_rst_pop", 32'(bus.pop), 32'd1);
    clr_reqs();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_clear", 32'({bus.push, bus.pop, bus.rsp_valid}), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("post_rst_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    set_req(1, 1'b1, OP_POP, 1, 0);
    set_req(0, 1'b1, OP_PUSH, 0, 1);
    set_req(3, 1'b1, OP_PUSH, 0, 2);
    @(negedge clk);
    chk("post_rst_ready", 32'(bus.req_ready), 32'b0001);
    tick();
    chk("post_rst_push", 32'({bus.push, bus.pop, bus.tree_id, bus.push_data}), 32'({1'b1, 1'b0, 2'd0, 16'd1}));
    clr_reqs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
